// File: rtl/ifetch_queue_if.sv
// rtl/ifetch_queue_if.sv - fetch-side memory port and decode-side instruction port bundle
//
// Purpose: groups the instruction-memory request/response signals and the
//          decode handshake signals used by ifetch_queue.
// Signals:
//   imem_req/imem_addr            request valid and word-aligned fetch address
//   imem_gnt                      request accepted this cycle
//   imem_rvalid/imem_rdata        in-order read data return
//   ins_valid/ins_ready           decode handshake on the queue head
//   ins_word/ins_pc               head instruction word and its address
//   ins_op/func_code              pre-split ins_word[31:26] / ins_word[5:0]
// Modports:
//   master  the fetch unit (drives requests and the decode side)
//   slave   the environment (memory and decoder)

interface ifetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        ins_valid;
   logic        ins_ready;
   logic [31:0] ins_word;
   logic [31:0] ins_pc;
   logic [5:0]  ins_op;
   logic [5:0]  func_code;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output ins_valid, ins_word, ins_pc, ins_op, func_code,
      input  ins_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  ins_valid, ins_word, ins_pc, ins_op, func_code,
      output ins_ready
   );
endinterface

// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch unit with in-order prefetch queue
//
// Purpose: keeps a fetch PC, issues word requests to instruction memory,
//          buffers returned words in a DEPTH-entry FIFO and presents the head
//          to decode. A redirect flushes the queue and discards responses to
//          requests that were already in flight.
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   redirect     taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc  new fetch address, low two bits ignored
//   busy         requests outstanding or words queued
//   err          sticky: read data returned with nothing outstanding
//   bus          ifetch_queue_if master (memory port + decode port)

module ifetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          redirect,
   input  logic [31:0]   redirect_pc,
   output logic          busy,
   output logic          err,
   ifetch_queue_if.master bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int PW = AW + 2;

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

   state_t        r_state, w_state_nxt;
   logic [31:0]   r_fetch_pc, r_resp_pc;
   logic [CW-1:0] r_count, w_count_nxt;
   logic [PW-1:0] r_pending, r_discard, w_pending_nxt, w_discard_nxt;
   logic [AW-1:0] r_wptr, r_rptr;
   logic [31:0]   r_word [DEPTH];
   logic [31:0]   r_pc   [DEPTH];
   logic          r_err;

   logic          w_req, w_grant, w_rv_live, w_push, w_pop, w_valid;
   logic [PW:0]   w_occupancy;
   logic [31:0]   w_redirect_pc, w_head_word;

   // Words already owed to the queue (queued + live in-flight) must never
   // exceed DEPTH, which is what guarantees a push always finds a free slot.
   always_comb begin
      w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
      w_occupancy   = {2'b00, r_count} + {1'b0, r_pending} - {1'b0, r_discard};
      w_req         = (r_state != S_BOOT) && !redirect
                      && (w_occupancy < (PW+1)'(DEPTH))
                      && (r_pending < PW'(2 * DEPTH));
      w_grant       = w_req && bus.imem_gnt;
      w_rv_live     = bus.imem_rvalid && (r_pending != '0);
      w_valid       = (r_count != '0);
      // A redirect drops this cycle's returning word and makes any pop moot.
      w_push        = w_rv_live && (r_discard == '0) && !redirect;
      w_pop         = w_valid && bus.ins_ready && !redirect;
      w_pending_nxt = r_pending + PW'(w_grant) - PW'(w_rv_live);
      if (redirect) begin
         w_discard_nxt = r_pending - PW'(w_rv_live);
         w_count_nxt   = '0;
      end else begin
         w_discard_nxt = r_discard - PW'(w_rv_live && (r_discard != '0));
         w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_BOOT:  w_state_nxt = S_RUN;
         S_RUN:   if (w_discard_nxt != '0) w_state_nxt = S_FLUSH;
         S_FLUSH: if (w_discard_nxt == '0) w_state_nxt = S_RUN;
         default: w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_BOOT;
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_count    <= '0;
         r_pending  <= '0;
         r_discard  <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_pending <= w_pending_nxt;
         r_discard <= w_discard_nxt;
         if (bus.imem_rvalid && (r_pending == '0))
            r_err <= 1'b1;
         if (redirect) begin
            r_fetch_pc <= w_redirect_pc;
            r_resp_pc  <= w_redirect_pc;
            r_wptr     <= '0;
            r_rptr     <= '0;
         end else begin
            if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_push) begin
               r_resp_pc <= r_resp_pc + 32'd4;
               r_wptr    <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
         end
      end
   end

   // Queue storage carries no reset; r_count alone decides what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_word[r_wptr] <= bus.imem_rdata;
         r_pc[r_wptr]   <= r_resp_pc;
      end
   end

   always_comb begin
      w_head_word    = w_valid ? r_word[r_rptr] : 32'h0;
      bus.imem_req   = w_req;
      bus.imem_addr  = r_fetch_pc;
      bus.ins_valid  = w_valid;
      bus.ins_word   = w_head_word;
      bus.ins_pc     = w_valid ? r_pc[r_rptr] : 32'h0;
      bus.ins_op     = w_head_word[31:26];
      bus.func_code  = w_head_word[5:0];
      busy           = (r_pending != '0) || w_valid;
      err            = r_err;
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - self-checking bench for ifetch_queue

module tb_ifetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        busy, err;

   ifetch_queue_if bus();

   ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
      .busy(busy), .err(err), .bus(bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   logic        rv_drv = 1'b0;
   logic [31:0] rd_drv = 32'h0;
   bit          rv_real = 1'b0;
   bit          rv_en = 1'b1;
   bit          spur = 1'b0;
   int          grant_cnt = 0;
   logic [31:0] rq[$];

   assign bus.imem_rvalid = rv_drv;
   assign bus.imem_rdata  = rd_drv;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_00C3;
   endfunction

   always @(posedge clk) begin
      if (rst_n) begin
         if (rv_real) void'(rq.pop_front());
         if (bus.imem_req && bus.imem_gnt) begin
            rq.push_back(bus.imem_addr);
            grant_cnt++;
         end
      end
      #2;
      if (!rst_n) begin
         rq.delete();
         rv_real = 1'b0; rv_drv = 1'b0;
      end else if (rv_en && rq.size() > 0) begin
         rv_real = 1'b1; rv_drv = 1'b1; rd_drv = mem_word(rq[0]);
      end else if (spur) begin
         rv_real = 1'b0; rv_drv = 1'b1; rd_drv = 32'hDEAD_BEEF;
      end else begin
         rv_real = 1'b0; rv_drv = 1'b0;
      end
   end

   // ---------------- behavioural model ----------------
   typedef struct packed { logic [31:0] pc; logic [31:0] word; } ent_t;
   ent_t        m_q[$];
   bit          m_tags[$];   // one per outstanding request: 1 = keep, 0 = stale
   bit          m_boot = 1'b1;
   logic [31:0] m_fpc = RESET_PC;
   logic [31:0] m_rpc = RESET_PC;
   bit          m_err = 1'b0;

   function automatic bit exp_req();
      int keep = 0;
      foreach (m_tags[i]) if (m_tags[i]) keep++;
      return !m_boot && !redirect && (m_q.size() + keep < DEPTH) && (m_tags.size() < 2 * DEPTH);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit g;
      bit k;
      if (!rst_n) begin
         m_boot = 1'b1; m_fpc = RESET_PC; m_rpc = RESET_PC;
         m_q.delete(); m_tags.delete(); m_err = 1'b0;
      end else begin
         g = exp_req() && bus.imem_gnt;
         if (bus.ins_ready && m_q.size() > 0 && !redirect) void'(m_q.pop_front());
         if (bus.imem_rvalid) begin
            if (m_tags.size() == 0) m_err = 1'b1;
            else begin
               k = m_tags.pop_front();
               if (k && !redirect) begin
                  m_q.push_back('{pc: m_rpc, word: bus.imem_rdata});
                  m_rpc = m_rpc + 32'd4;
               end
            end
         end
         if (redirect) begin
            m_q.delete();
            foreach (m_tags[i]) m_tags[i] = 1'b0;
            m_fpc = {redirect_pc[31:2], 2'b00};
            m_rpc = m_fpc;
         end
         if (g) begin
            m_tags.push_back(1'b1);
            m_fpc = m_fpc + 32'd4;
         end
         m_boot = 1'b0;
      end
   end

   always @(negedge clk) begin
      logic [31:0] ew, ep;
      bit ev;
      ev = (m_q.size() != 0);
      ew = ev ? m_q[0].word : 32'h0;
      ep = ev ? m_q[0].pc : 32'h0;
      chk("m_imem_req",  32'(bus.imem_req),  32'(exp_req()));
      chk("m_imem_addr", bus.imem_addr,      m_fpc);
      chk("m_ins_valid", 32'(bus.ins_valid), 32'(ev));
      chk("m_ins_word",  bus.ins_word,       ew);
      chk("m_ins_pc",    bus.ins_pc,         ep);
      chk("m_ins_op",    32'(bus.ins_op),    32'(ew[31:26]));
      chk("m_func_code", 32'(bus.func_code), 32'(ew[5:0]));
      chk("m_busy",      32'(busy),          32'(ev || m_tags.size() != 0));
      chk("m_err",       32'(err),           32'(m_err));
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_head(input string tag, input logic [31:0] exp_pc);
      int n = 0;
      @(negedge clk);
      while (!bus.ins_valid && n < 30) begin @(negedge clk); n++; end
      chk({tag, "_valid"}, 32'(bus.ins_valid), 32'd1);
      chk({tag, "_pc"}, bus.ins_pc, exp_pc);
   endtask

   initial begin
      int g0;
      bus.imem_gnt  = 1'b0;
      bus.ins_ready = 1'b0;

      // reset state
      step(3);
      @(negedge clk);
      chk("rst_req",   32'(bus.imem_req),  32'd0);
      chk("rst_addr",  bus.imem_addr,      RESET_PC);
      chk("rst_valid", 32'(bus.ins_valid), 32'd0);
      chk("rst_busy",  32'(busy),          32'd0);

      // streaming latency from reset release
      step();
      rst_n = 1'b1; bus.imem_gnt = 1'b1; bus.ins_ready = 1'b1;
      @(negedge clk); chk("boot_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk); chk("first_req", 32'(bus.imem_req), 32'd1);
                      chk("first_addr", bus.imem_addr, 32'h0);
      @(negedge clk); chk("lat2_valid", 32'(bus.ins_valid), 32'd0);
      @(negedge clk); chk("lat3_valid", 32'(bus.ins_valid), 32'd1);
                      chk("lat3_pc", bus.ins_pc, 32'h0);
      @(negedge clk); chk("stream_pc1", bus.ins_pc, 32'h4);
      repeat (4) @(negedge clk);

      // asynchronous reset pulse, then fill with ready low
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      chk("arst_req",   32'(bus.imem_req),  32'd0);
      chk("arst_valid", 32'(bus.ins_valid), 32'd0);
      chk("arst_busy",  32'(busy),          32'd0);
      chk("arst_addr",  bus.imem_addr,      RESET_PC);
      chk("arst_pc",    bus.ins_pc,         32'h0);
      step();
      rst_n = 1'b1; bus.ins_ready = 1'b0;
      g0 = grant_cnt;
      step(12);
      @(negedge clk);
      chk("full_grants", 32'(grant_cnt - g0), 32'd4);
      chk("full_req",    32'(bus.imem_req),   32'd0);
      chk("full_pc",     bus.ins_pc,          32'h0);
      step();
      bus.ins_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); chk("drain_order_pc", bus.ins_pc, 32'(4 * i));
      end

      // redirect with two requests outstanding
      step();
      bus.imem_gnt = 1'b0;
      step(8);
      rv_en = 1'b0; bus.imem_gnt = 1'b1;
      step(2);
      bus.imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      chk("r2_busy", 32'(busy), 32'd1);
      chk("r2_req",  32'(bus.imem_req), 32'd0);
      step();
      redirect = 1'b0; bus.imem_gnt = 1'b1; rv_en = 1'b1;
      @(negedge clk); chk("r2_addr", bus.imem_addr, 32'h100);
      wait_head("r2_head", 32'h100);

      // redirect coinciding with a returning word and a pop
      step(6);
      redirect = 1'b1; redirect_pc = 32'h200;
      @(negedge clk);
      chk("r3_pre_rvalid", 32'(bus.imem_rvalid), 32'd1);
      chk("r3_pre_valid",  32'(bus.ins_valid),   32'd1);
      step();
      redirect = 1'b0;
      @(negedge clk);
      chk("r3_valid", 32'(bus.ins_valid), 32'd0);
      chk("r3_addr",  bus.imem_addr,      32'h200);
      wait_head("r3_head", 32'h200);

      // unaligned redirect target
      step(3);
      redirect = 1'b1; redirect_pc = 32'h103;
      step();
      redirect = 1'b0;
      @(negedge clk); chk("r4_addr", bus.imem_addr, 32'h100);
      wait_head("r4_head", 32'h100);

      // read data with nothing outstanding
      step();
      bus.imem_gnt = 1'b0;
      step(10);
      @(negedge clk); chk("idle_busy", 32'(busy), 32'd0);
      step();
      spur = 1'b1;
      step();
      spur = 1'b0;
      @(negedge clk);
      chk("err_set",   32'(err),           32'd1);
      chk("err_valid", 32'(bus.ins_valid), 32'd0);
      step(3);
      @(negedge clk); chk("err_sticky", 32'(err), 32'd1);
      @(posedge clk); #1 rst_n = 1'b0;
      #1 chk("err_rst", 32'(err), 32'd0);
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
